// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// UART_RX_PARITY_EN adds the PARITY state for 8E1 framing.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 103;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin; presets to idle-high on RESET.
module uart_rx_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic rx_i,
    output logic rx_s_o
);

    logic [1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx_s_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a one-entry valid/ready byte slot.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity checking.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 VALID,
    input  logic                 READY,
    output logic                 BUSY,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int IW       = $clog2(DATA_BITS);

    // The counter hits zero on the sample cycle, so loads are one less than the span.
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev_q;
    rx_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 stop_good;
    logic                 tick;
    logic                 rx_fall;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err_q;
`endif

    uart_rx_sync u_sync (
        .CLK    (CLK),
        .RESET  (RESET),
        .rx_i   (RX),
        .rx_s_o (rx_s)
    );

    assign tick    = (cnt_q == '0);
    assign rx_fall = rx_prev_q & ~rx_s;

    // NOTE: give every always_comb output a value up front; a path that skips an
    // assignment would otherwise infer a latch.
    always_comb begin
        shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
        stop_good = rx_s;
`ifdef UART_RX_PARITY_EN
        stop_good = rx_s & ~parity_err_q;
`endif
    end

    // NOTE: the data register is reset along with control state so DATA reads 0x00
    // after RESET; it is a single register, not a memory array.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_prev_q   <= rx_s;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            if (valid_q && READY) begin
                valid_q <= 1'b0;
            end

            if (state_q != ST_IDLE && state_q != ST_BREAK) begin
                cnt_q <= tick ? BIT_LOAD : cnt_q - 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rx_fall) begin
                        state_q <= ST_START;
                        cnt_q   <= HALF_LOAD;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift_q <= shift_d;
                        if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        parity_err_q <= (rx_s != ^shift_q);
                        state_q      <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        if (!rx_s) begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end else if (!stop_good) begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            // Returning at mid-stop leaves half a bit to catch the next start edge.
                            state_q <= ST_IDLE;
                            if (!valid_q || READY) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign DATA      = data_q;
    assign VALID     = valid_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign FRAME_ERR = frame_err_q;
    assign OVERRUN   = overrun_q;

endmodule
